signature_checker: RTL and testbench

Response-side counterpart to the stimulus/signature generator used around the `micro` core. It compresses a stream of 8-bit observation words into a 16-bit add-rotate signature over a fixed window. At each window end it handshakes for an expected signature from an answer table, compares the two, and reports pass/fail. It sits between the micro's scrambled debug bus and the answer-table ROM/host.

---
 rtl/signature_checker.sv | 87 ++++++++
 tb/tb_signature_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/signature_checker.sv
// signature_checker
//   Compresses a stream of 8-bit observation words into a 16-bit add-rotate
//   signature over a window of WINDOW words. At the end of each window it
//   waits for an expected signature, compares the two and reports the result.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   obs_valid/obs_data observation word input, accepted while obs_ready=1
//   obs_ready          high while accumulating a window
//   exp_valid/exp_sig  expected signature, accepted while exp_ready=1
//   exp_ready          high while waiting for the expected signature
//   signature          current accumulator (direct register output)
//   sig_done           one-cycle pulse when a compare completes
//   match              result of the last compare, held until the next one
//   err_count          mismatching windows, saturates at 8'hFF
//   win_count          completed compares, wraps modulo 256
module signature_checker #(
  parameter int          WINDOW   = 255,
  parameter logic [15:0] INIT_SIG = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        obs_valid,
  input  logic [7:0]  obs_data,
  output logic        obs_ready,
  input  logic        exp_valid,
  input  logic [15:0] exp_sig,
  output logic        exp_ready,
  output logic [15:0] signature,
  output logic        sig_done,
  output logic        match,
  output logic [7:0]  err_count,
  output logic [7:0]  win_count
);

  typedef enum logic {ACCUM, WAIT_EXP} state_t;

  localparam logic [15:0] LAST = 16'(WINDOW - 1);

  state_t      state;
  logic [15:0] cnt;

  // Handshake readies decode the state register only, so no input reaches them.
  assign obs_ready = (state == ACCUM);
  assign exp_ready = (state == WAIT_EXP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      signature <= INIT_SIG;
      cnt       <= '0;
      match     <= 1'b0;
      sig_done  <= 1'b0;
      err_count <= '0;
      win_count <= '0;
    end else begin
      sig_done <= 1'b0;
      case (state)
        ACCUM: begin
          if (obs_valid) begin
            // Add into the low byte (carry dropped), then rotate left by one.
            signature <= {signature[14:8], signature[7:0] + obs_data, signature[15]};
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= WAIT_EXP;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        WAIT_EXP: begin
          if (exp_valid) begin
            match     <= (signature == exp_sig);
            sig_done  <= 1'b1;
            win_count <= win_count + 8'd1;
            if (signature != exp_sig && err_count != 8'hFF)
              err_count <= err_count + 8'd1;
            signature <= INIT_SIG;
            cnt       <= '0;
            state     <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signature_checker.sv
// Bench for signature_checker: three instances (WINDOW=3/INIT=0000,
// WINDOW=1/INIT=8000, WINDOW=1/INIT=00FF) driven by directed steps; compare
// results are pushed to a scoreboard at the handshake and popped on sig_done.
module tb_signature_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ov   [3];
  logic [7:0]  od   [3];
  logic        ordy [3];
  logic        ev   [3];
  logic [15:0] es   [3];
  logic        erdy [3];
  logic [15:0] sig  [3];
  logic        sd   [3];
  logic        mt   [3];
  logic [7:0]  ec   [3];
  logic [7:0]  wc   [3];

  signature_checker #(.WINDOW(3), .INIT_SIG(16'h0000)) u0 (
    .clk(clk), .reset(rst), .obs_valid(ov[0]), .obs_data(od[0]), .obs_ready(ordy[0]),
    .exp_valid(ev[0]), .exp_sig(es[0]), .exp_ready(erdy[0]), .signature(sig[0]),
    .sig_done(sd[0]), .match(mt[0]), .err_count(ec[0]), .win_count(wc[0]));
  signature_checker #(.WINDOW(1), .INIT_SIG(16'h8000)) u1 (
    .clk(clk), .reset(rst), .obs_valid(ov[1]), .obs_data(od[1]), .obs_ready(ordy[1]),
    .exp_valid(ev[1]), .exp_sig(es[1]), .exp_ready(erdy[1]), .signature(sig[1]),
    .sig_done(sd[1]), .match(mt[1]), .err_count(ec[1]), .win_count(wc[1]));
  signature_checker #(.WINDOW(1), .INIT_SIG(16'h00FF)) u2 (
    .clk(clk), .reset(rst), .obs_valid(ov[2]), .obs_data(od[2]), .obs_ready(ordy[2]),
    .exp_valid(ev[2]), .exp_sig(es[2]), .exp_ready(erdy[2]), .signature(sig[2]),
    .sig_done(sd[2]), .match(mt[2]), .err_count(ec[2]), .win_count(wc[2]));

  localparam logic [15:0] INIT [3] = '{16'h0000, 16'h8000, 16'h00FF};

  typedef struct packed {
    logic       m;
    logic [7:0] e;
    logic [7:0] w;
  } sb_t;

  sb_t         sb [$];
  logic [15:0] msig [3];
  logic [7:0]  merr [3];
  logic [7:0]  mwin [3];
  int          n_chk  = 0;
  int          n_fail = 0;

  // Reference update: add into low byte, then rotate the word left by one.
  function automatic logic [15:0] nxt(logic [15:0] s, logic [7:0] d);
    logic [15:0] t;
    t = {s[15:8], 8'(s[7:0] + d)};
    return {t[14:0], t[15]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      msig[k] = INIT[k];
      merr[k] = 8'h00;
      mwin[k] = 8'h00;
    end
    sb.delete();
  endtask

  task automatic word(int k, logic [7:0] d);
    int t = 0;
    while (!ordy[k] && t < 10) begin step(); t++; end
    chk("obs_ready", ordy[k], 1);
    ov[k] = 1'b1; od[k] = d;
    step();
    ov[k] = 1'b0;
    msig[k] = nxt(msig[k], d);
    chk("signature", sig[k], msig[k]);
  endtask

  task automatic expect_sig(int k, logic [15:0] e);
    int  t = 0;
    sb_t x;
    while (!erdy[k] && t < 10) begin step(); t++; end
    chk("exp_ready", erdy[k], 1);
    ev[k] = 1'b1; es[k] = e;
    mwin[k] = mwin[k] + 8'd1;
    if (msig[k] != e && merr[k] != 8'hFF) merr[k] = merr[k] + 8'd1;
    sb.push_back('{m: (msig[k] == e), e: merr[k], w: mwin[k]});
    step();
    ev[k] = 1'b0;
    chk("sig_done", sd[k], 1);
    if (sd[k] && sb.size() > 0) begin
      x = sb.pop_front();
      chk("match", mt[k], x.m);
      chk("err_count", ec[k], x.e);
      chk("win_count", wc[k], x.w);
    end else begin
      sb.delete();
    end
    msig[k] = INIT[k];
    chk("sig_reinit", sig[k], msig[k]);
    chk("obs_ready_back", ordy[k], 1);
    step();
    chk("sig_done_pulse", sd[k], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ov[k] = 1'b0; od[k] = 8'h00; ev[k] = 1'b0; es[k] = 16'h0000;
    end
    step(); step();
    rst = 1'b0;
    model_reset();

    // Reset state
    chk("rst_sig0", sig[0], 16'h0000);
    chk("rst_sig1", sig[1], 16'h8000);
    chk("rst_match", mt[0], 0);
    chk("rst_done", sd[0], 0);
    chk("rst_err", ec[0], 8'h00);
    chk("rst_win", wc[0], 8'h00);
    chk("rst_ordy", ordy[0], 1);
    chk("rst_erdy", erdy[0], 0);

    // Basic window: 0002, 0006, 000E
    word(0, 8'h01); chk("w1", sig[0], 16'h0002);
    word(0, 8'h01); chk("w2", sig[0], 16'h0006);
    word(0, 8'h01); chk("w3", sig[0], 16'h000E);
    chk("ordy_drop", ordy[0], 0);
    chk("erdy_rise", erdy[0], 1);
    expect_sig(0, 16'h000E);

    // Rotate of bit 15 and dropped carry with WINDOW=1
    word(1, 8'h00); chk("rot", sig[1], 16'h0001);
    expect_sig(1, 16'h0001);
    word(2, 8'h01); chk("carry", sig[2], 16'h0000);
    expect_sig(2, 16'h0000);

    // Mismatch followed by a matching window
    for (int i = 0; i < 3; i++) word(0, 8'h01);
    expect_sig(0, 16'h000F);
    chk("mm_match", mt[0], 0);
    chk("mm_err", ec[0], 8'h01);
    for (int i = 0; i < 3; i++) word(0, 8'h01);
    expect_sig(0, 16'h000E);
    chk("mm_err_hold", ec[0], 8'h01);

    // exp_valid during ACCUM is ignored
    ev[0] = 1'b1; es[0] = 16'h0000;
    step(); step();
    chk("accum_exp_done", sd[0], 0);
    chk("accum_exp_win", wc[0], mwin[0]);
    chk("accum_exp_erdy", erdy[0], 0);
    chk("accum_exp_sig", sig[0], 16'h0000);
    ev[0] = 1'b0;

    // Back-pressure: valid 1,0,1,0,1
    word(0, 8'h01); step(); chk("bp_idle1", sig[0], 16'h0002);
    word(0, 8'h01); step(); chk("bp_idle2", sig[0], 16'h0006);
    word(0, 8'h01); chk("bp_final", sig[0], 16'h000E);
    ov[0] = 1'b1; od[0] = 8'h55;
    step();
    ov[0] = 1'b0;
    chk("wait_obs_sig", sig[0], 16'h000E);
    chk("wait_obs_erdy", erdy[0], 1);
    expect_sig(0, 16'h000E);

    // Reset mid-window discards partial work
    word(0, 8'h01); word(0, 8'h01);
    rst = 1'b1; step(); rst = 1'b0;
    model_reset();
    chk("mid_rst_sig", sig[0], 16'h0000);
    chk("mid_rst_win", wc[0], 8'h00);
    chk("mid_rst_ordy", ordy[0], 1);
    word(0, 8'h01); word(0, 8'h01);
    chk("fresh_not_done", ordy[0], 1);
    word(0, 8'h01); chk("fresh_sig", sig[0], 16'h000E);
    expect_sig(0, 16'h000E);

    // Saturation: 256 mismatching windows
    for (int i = 0; i < 256; i++) begin
      word(1, 8'h00);
      expect_sig(1, 16'h0000);
    end
    chk("sat_err", ec[1], 8'hFF);
    chk("sat_win", wc[1], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
